// File: rtl/spc_stack_ctrl_if.sv
// spc_stack_ctrl_if -- request/response and SPC RAM port-A bundle for the
// SPC stack controller.
//
// Signals:
//   push, pop, push_data, clr_flags       requester -> controller
//   req_ready, pop_data, pop_valid        controller -> requester
//   spcptr, depth, overflow, underflow    controller status
//   ram_address, ram_data, ram_wren,
//   ram_rden                              controller -> SPC RAM port A
//   ram_q                                 SPC RAM port A -> controller
//
// Modports:
//   slave  - the stack controller
//   master - the environment (microsequencer plus SPC RAM)
interface spc_stack_ctrl_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 19
);
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  clr_flags;
    logic                  req_ready;
    logic [DATA_WIDTH-1:0] pop_data;
    logic                  pop_valid;
    logic [ADDR_WIDTH-1:0] spcptr;
    logic [ADDR_WIDTH:0]   depth;
    logic                  overflow;
    logic                  underflow;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0] ram_data;
    logic                  ram_wren;
    logic                  ram_rden;
    logic [DATA_WIDTH-1:0] ram_q;

    modport slave (
        input  push, pop, push_data, clr_flags, ram_q,
        output req_ready, pop_data, pop_valid, spcptr, depth,
               overflow, underflow, ram_address, ram_data, ram_wren, ram_rden
    );

    modport master (
        output push, pop, push_data, clr_flags, ram_q,
        input  req_ready, pop_data, pop_valid, spcptr, depth,
               overflow, underflow, ram_address, ram_data, ram_wren, ram_rden
    );
endinterface

// File: rtl/spc_stack_ctrl.sv
// spc_stack_ctrl -- controller for the 32-entry SPC (subroutine PC) stack.
//
// Owns the stack pointer and depth count, converts push / pop / exchange
// requests into port-A strobes on the SPC dual-port RAM and returns popped
// words with a one-cycle valid pulse.
//
// Ports:
//   clk_a  - clock, rising edge
//   reset  - synchronous, active-high
//   bus    - spc_stack_ctrl_if.slave: request handshake, status, RAM port A
//
// Parameters:
//   ADDR_WIDTH - SPC RAM address width (depth = 2**ADDR_WIDTH)
//   DATA_WIDTH - SPC word width
//   RD_LATENCY - RAM port-A read latency in cycles, 1 or 2
module spc_stack_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 19,
    parameter int RD_LATENCY = 2
) (
    input  logic              clk_a,
    input  logic              reset,
    spc_stack_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_WAIT,
        S_CAP
    } state_t;

    // Anything other than 1 is treated as the two-cycle RAM.
    localparam bit LAT2 = (RD_LATENCY != 1);

    localparam logic [ADDR_WIDTH:0] DEPTH_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] spcptr_q, spcptr_d;
    logic [ADDR_WIDTH:0]   depth_q, depth_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;
    logic                  pop_valid_q, pop_valid_d;
    logic                  ram_wren_q, ram_wren_d;
    logic                  ram_rden_q, ram_rden_d;
    logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
    logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
    logic                  xchg_q, xchg_d;

    logic                  set_ovf;
    logic                  set_unf;
    logic                  req_ready;

    assign req_ready = (state_q == S_IDLE) && !reset;

    always_comb begin
        state_d       = state_q;
        spcptr_d      = spcptr_q;
        depth_d       = depth_q;
        pop_data_d    = pop_data_q;
        pop_valid_d   = 1'b0;
        ram_wren_d    = ram_wren_q;
        ram_rden_d    = ram_rden_q;
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        xchg_d        = xchg_q;
        set_ovf       = 1'b0;
        set_unf       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_ready && bus.push && !bus.pop) begin
                    // Push pre-increments: spcptr always names the top entry.
                    spcptr_d      = spcptr_q + ADDR_WIDTH'(1);
                    ram_address_d = spcptr_q + ADDR_WIDTH'(1);
                    ram_data_d    = bus.push_data;
                    ram_wren_d    = 1'b1;
                    if (depth_q == DEPTH_MAX) begin
                        set_ovf = 1'b1;  // wrap overwrites the oldest entry
                    end else begin
                        depth_d = depth_q + (ADDR_WIDTH+1)'(1);
                    end
                    state_d = S_WR;
                end else if (req_ready && bus.pop && !bus.push) begin
                    ram_address_d = spcptr_q;
                    ram_rden_d    = 1'b1;
                    spcptr_d      = spcptr_q - ADDR_WIDTH'(1);
                    xchg_d        = 1'b0;
                    if (depth_q == '0) begin
                        set_unf = 1'b1;  // still reads: returns a stale word
                    end else begin
                        depth_d = depth_q - (ADDR_WIDTH+1)'(1);
                    end
                    state_d = S_RD;
                end else if (req_ready && bus.push && bus.pop) begin
                    // Exchange: read the top, then write push_data back to
                    // the same slot. ram_data is parked here so the write
                    // after capture needs no extra holding register.
                    ram_address_d = spcptr_q;
                    ram_rden_d    = 1'b1;
                    ram_data_d    = bus.push_data;
                    xchg_d        = 1'b1;
                    state_d       = S_RD;
                end
            end
            S_WR: begin
                ram_wren_d = 1'b0;
                state_d    = S_IDLE;
            end
            S_RD: begin
                ram_rden_d = 1'b0;
                state_d    = LAT2 ? S_WAIT : S_CAP;
            end
            S_WAIT: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                pop_data_d  = bus.ram_q;
                pop_valid_d = 1'b1;
                if (xchg_q) begin
                    ram_wren_d = 1'b1;
                    xchg_d     = 1'b0;
                    state_d    = S_WR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Set takes priority over a coincident clear.
        overflow_d  = set_ovf || (overflow_q  && !bus.clr_flags);
        underflow_d = set_unf || (underflow_q && !bus.clr_flags);
    end

    always_ff @(posedge clk_a) begin
        if (reset) begin
            state_q       <= S_IDLE;
            spcptr_q      <= '0;
            depth_q       <= '0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            pop_data_q    <= '0;
            pop_valid_q   <= 1'b0;
            ram_wren_q    <= 1'b0;
            ram_rden_q    <= 1'b0;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            xchg_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            spcptr_q      <= spcptr_d;
            depth_q       <= depth_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
            pop_data_q    <= pop_data_d;
            pop_valid_q   <= pop_valid_d;
            ram_wren_q    <= ram_wren_d;
            ram_rden_q    <= ram_rden_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            xchg_q        <= xchg_d;
        end
    end

    assign bus.req_ready   = req_ready;
    assign bus.pop_data    = pop_data_q;
    assign bus.pop_valid   = pop_valid_q;
    assign bus.spcptr      = spcptr_q;
    assign bus.depth       = depth_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
    assign bus.ram_address = ram_address_q;
    assign bus.ram_data    = ram_data_q;
    assign bus.ram_wren    = ram_wren_q;
    assign bus.ram_rden    = ram_rden_q;

endmodule

// File: doc/spc_stack_ctrl.md
# spc_stack_ctrl

Stack controller for the 32-entry SPC (subroutine PC) stack. Owns the 5-bit SPC pointer and depth count, turns push/pop/exchange requests from the microsequencer into port-A strobes on the 32x19 SPC dual-port RAM, and returns popped words with a valid pulse. Sits directly upstream of the SPC RAM (drives its port A) and downstream of the microsequencer call/return logic.

## Interface
- ADDR_WIDTH, 5, SPC RAM address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 19, SPC word width.
- RD_LATENCY, 2, SPC RAM port-A read latency in clk_a cycles; legal values 1 or 2.

- clk_a  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- push  in  1  push request; sampled only when req_ready=1.
- pop  in  1  pop request; sampled only when req_ready=1.
- push_data  in  DATA_WIDTH  word to push.
- clr_flags  in  1  clears overflow/underflow sticky flags.
- req_ready  out  1  controller idle, request accepted this cycle if push|pop.
- pop_data  out  DATA_WIDTH  popped word, registered, held until next pop completes.
- pop_valid  out  1  one-cycle pulse: pop_data updated.
- spcptr  out  ADDR_WIDTH  current top-of-stack index.
- depth  out  ADDR_WIDTH+1  valid entries, 0..32.
- overflow  out  1  sticky: push performed at depth 32.
- underflow  out  1  sticky: pop performed at depth 0.
- ram_address  out  ADDR_WIDTH  to RAM address_a.
- ram_data  out  DATA_WIDTH  to RAM data_a.
- ram_wren  out  1  to RAM wren_a.
- ram_rden  out  1  to RAM rden_a.
- ram_q  in  DATA_WIDTH  from RAM q_a.

## Operation
- spcptr points at the current top entry. Pointer arithmetic modulo 32 (ADDR_WIDTH bits, natural wrap 31->0, 0->31).
- States: IDLE, WR, RD, WAIT, CAP. req_ready = (state==IDLE) & ~reset.
- Push (push=1, pop=0) in IDLE: spcptr <= spcptr+1; ram_address <= spcptr+1, ram_data <= push_data, ram_wren <= 1; -> WR. WR: drop ram_wren -> IDLE.
- Pop (pop=1, push=0) in IDLE: ram_address <= spcptr, ram_rden <= 1; spcptr <= spcptr-1; -> RD. RD: ram_rden <= 0; -> WAIT if RD_LATENCY=2, else -> CAP. WAIT: -> CAP. CAP: pop_data <= ram_q, pop_valid <= 1 next cycle; -> IDLE.
- Exchange (push=1, pop=1) in IDLE: read at spcptr as for pop, spcptr unchanged; after CAP -> WR writing push_data (latched at accept) to same address; pop_valid pulses with old top. depth unchanged, no flags.
- depth: push increments, saturates at 32; pop decrements, saturates at 0.
- Push at depth 32: still performed (overwrites oldest entry), overflow <= 1. Pop at depth 0: still performed (returns stale word, pointer wraps), underflow <= 1.
- clr_flags clears both flags; if same cycle sets a flag, set wins.
- Requests outside IDLE are ignored (not queued); requester must hold until req_ready.
- ram_rden and ram_wren never high together.

## Timing
- Reset values: state IDLE, spcptr 0, depth 0, overflow 0, underflow 0, pop_data 0, pop_valid 0, ram_wren 0, ram_rden 0, ram_address 0, ram_data 0; req_ready 0 while reset high.
- Reset mid-operation: abort at next edge, in-flight read discarded, no pop_valid.
- All RAM-side outputs registered. Push accepted in cycle T: ram_wren high in T+1, req_ready high in T+2.
- Pop accepted in T: ram_rden high in T+1, ram_q valid in T+1+RD_LATENCY, pop_valid high in T+2+RD_LATENCY (T+4 for latency 2), req_ready high same cycle as pop_valid.
- Exchange accepted in T: pop_valid in T+2+RD_LATENCY, ram_wren same cycle, req_ready one cycle later.
- spcptr/depth update at the accept edge (visible T+1).

## Test plan
- Reset, then push 19'o1234 ... 5 words -> ram_wren at addresses 1..5 with matching data, spcptr=5, depth=5, req_ready low every other cycle.
- Pop 5 times (RD_LATENCY=2) -> pop_valid 4 cycles after each accept, data in reverse push order, spcptr=0, depth=0, no flags.
- 33 pushes from reset -> pointer wraps 31->0->1, depth saturates 32, overflow=1 after 33rd; clr_flags -> overflow=0.
- Pop at depth 0 -> ram read at address 0, spcptr=31, underflow=1, pop_valid still pulses.
- Exchange with top=19'o7 at ptr 3, push_data 19'o42 -> pop_data=19'o7, then RAM[3] written 19'o42, spcptr=3, depth unchanged.
- Reset asserted in WAIT during pop -> no pop_valid, spcptr=0, depth=0, req_ready 1 cycle after reset drops; repeat with RD_LATENCY=1 (pop_valid at T+3).
